// File: rtl/pcs100_rx_decoder_if.sv
// Receive-side PCS byte interface: descrambled line bits in, framed bytes out.
// master = line/bit-stream side, slave = decoder side.
interface pcs100_rx_decoder_if #(
    parameter int LEN_W = 11
);
    logic             rx_bit;
    logic             rx_bit_en;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_sof;
    logic             rx_eof;
    logic             rx_err;
    logic             rx_active;
    logic [LEN_W-1:0] rx_len;

    modport master (
        output rx_bit, rx_bit_en,
        input  rx_data, rx_valid, rx_sof, rx_eof, rx_err, rx_active, rx_len
    );

    modport slave (
        input  rx_bit, rx_bit_en,
        output rx_data, rx_valid, rx_sof, rx_eof, rx_err, rx_active, rx_len
    );
endinterface

// File: rtl/pcs100_rx_decoder.sv
// 100BASE-TX receive PCS decoder: J/K alignment, 4B5B decode, byte assembly
// (low nibble first) and start/end/error framing. All outputs registered.
module pcs100_rx_decoder #(
    parameter int MAX_BYTES = 1518,
    parameter int LEN_W     = 11
) (
    input  logic               clk125,
    input  logic               rst_n,
    pcs100_rx_decoder_if.slave rx_if
);
    localparam logic [4:0]       SYM_I   = 5'b11111;
    localparam logic [4:0]       SYM_J   = 5'b11000;
    localparam logic [4:0]       SYM_K   = 5'b10001;
    localparam logic [4:0]       SYM_T   = 5'b01101;
    localparam logic [4:0]       SYM_R   = 5'b00111;
    localparam logic [9:0]       SYM_JK  = {SYM_J, SYM_K};
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        S_HUNT,
        S_DATA,
        S_END
    } state_t;

    state_t           state_q;
    // Only nine bits of history are stored: together with the arriving bit
    // they form the full 10-bit window, the oldest bit is never looked at.
    logic [8:0]       sr_q;
    logic [9:0]       sr_d;
    logic [2:0]       bit_cnt_q;
    logic             nib_hi_q;
    logic [3:0]       nib_lo_q;
    logic             pend_err_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             sof_q;
    logic             eof_q;
    logic             err_q;
    logic             active_q;
    logic [LEN_W-1:0] len_q;

    logic [4:0]       grp;
    logic             grp_done;
    logic             grp_is_data;
    logic [3:0]       grp_nib;

    // Shift window including the bit arriving this cycle; group = low 5 bits.
    always_comb begin
        sr_d = {sr_q, rx_if.rx_bit};
    end

    assign grp      = sr_d[4:0];
    assign grp_done = (bit_cnt_q == 3'd4);

    // 4B5B data-group decode.
    always_comb begin
        grp_is_data = 1'b1;
        grp_nib     = 4'h0;
        case (grp)
            5'b11110: grp_nib = 4'h0;
            5'b01001: grp_nib = 4'h1;
            5'b10100: grp_nib = 4'h2;
            5'b10101: grp_nib = 4'h3;
            5'b01010: grp_nib = 4'h4;
            5'b01011: grp_nib = 4'h5;
            5'b01110: grp_nib = 4'h6;
            5'b01111: grp_nib = 4'h7;
            5'b10010: grp_nib = 4'h8;
            5'b10011: grp_nib = 4'h9;
            5'b10110: grp_nib = 4'hA;
            5'b10111: grp_nib = 4'hB;
            5'b11010: grp_nib = 4'hC;
            5'b11011: grp_nib = 4'hD;
            5'b11100: grp_nib = 4'hE;
            5'b11101: grp_nib = 4'hF;
            default:  grp_is_data = 1'b0;
        endcase
    end

    // Framing FSM with registered strobes; everything advances on rx_bit_en only.
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HUNT;
            sr_q       <= 9'h1FF;
            bit_cnt_q  <= 3'd0;
            nib_hi_q   <= 1'b0;
            nib_lo_q   <= 4'h0;
            pend_err_q <= 1'b0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            err_q      <= 1'b0;
            active_q   <= 1'b0;
            len_q      <= '0;
        end else begin
            // Strobes are single-cycle regardless of rx_bit_en.
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
            if (rx_if.rx_bit_en) begin
                sr_q <= sr_d[8:0];
                case (state_q)
                    S_HUNT: begin
                        if (sr_d == SYM_JK) begin
                            state_q    <= S_DATA;
                            bit_cnt_q  <= 3'd0;
                            nib_hi_q   <= 1'b0;
                            pend_err_q <= 1'b0;
                            len_q      <= '0;
                            active_q   <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (!grp_done) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else begin
                            bit_cnt_q <= 3'd0;
                            if (grp_is_data && !nib_hi_q) begin
                                nib_lo_q <= grp_nib;
                                nib_hi_q <= 1'b1;
                            end else if (grp_is_data && (len_q != MAX_LEN)) begin
                                data_q   <= {grp_nib, nib_lo_q};
                                valid_q  <= 1'b1;
                                sof_q    <= (len_q == '0);
                                len_q    <= len_q + LEN_ONE;
                                nib_hi_q <= 1'b0;
                            end else if (grp == SYM_T) begin
                                // Odd nibble count is reported at the end delimiter.
                                state_q    <= S_END;
                                pend_err_q <= nib_hi_q;
                            end else begin
                                // Overlong frame, premature I, or any invalid group.
                                eof_q    <= 1'b1;
                                err_q    <= 1'b1;
                                active_q <= 1'b0;
                                state_q  <= S_HUNT;
                            end
                        end
                    end
                    S_END: begin
                        if (!grp_done) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else begin
                            bit_cnt_q <= 3'd0;
                            eof_q     <= 1'b1;
                            err_q     <= (grp != SYM_R) || pend_err_q;
                            active_q  <= 1'b0;
                            state_q   <= S_HUNT;
                        end
                    end
                    default: state_q <= S_HUNT;
                endcase
            end
        end
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.rx_sof    = sof_q;
    assign rx_if.rx_eof    = eof_q;
    assign rx_if.rx_err    = err_q;
    assign rx_if.rx_active = active_q;
    assign rx_if.rx_len    = len_q;
endmodule

// File: doc/pcs100_rx_decoder.md
Name: pcs100_rx_decoder

Overview:
Receive-side 100BASE-TX PCS decoder: the counterpart of our 4B5B/MLT-3 transmit path. It takes the descrambled NRZ bit stream recovered from the line, bit-serial in transmit order (MSB of each 5-bit code group first). It finds code-group alignment from the J/K start delimiter, decodes 4B5B groups to nibbles and assembles bytes, low nibble first. It delivers a byte stream with start/end/error framing to the downstream MAC receive logic.

Parameters:
MAX_BYTES, 1518, max data bytes per frame after J/K (preamble remainder included); exceeding it aborts the frame.
LEN_W, 11, width of the rx_len byte counter.

Ports:
clk125  in  1  bit-rate clock.
rst_n  in  1  asynchronous active-low reset.
rx_bit  in  1  descrambled NRZ line bit.
rx_bit_en  in  1  rx_bit valid this cycle; all state advances only on rx_bit_en=1.
rx_data  out  8  decoded byte.
rx_valid  out  1  one-cycle strobe: rx_data valid.
rx_sof  out  1  asserted with the first rx_valid of a frame.
rx_eof  out  1  one-cycle end-of-frame strobe.
rx_err  out  1  asserted only together with rx_eof; frame ended abnormally.
rx_active  out  1  high from J/K detection until the cycle rx_eof is asserted.
rx_len  out  LEN_W  bytes delivered in the current/last frame; held after rx_eof, cleared at next J/K.

Behaviour:
- Reset (rst_n=0, async): all outputs 0, shift register 0x3FF (all I), state S_HUNT, counters 0.
- sr[9:0] shifts left on each rx_bit_en, new bit into sr[0]. Code group = sr[4:0]; sr[4] is the first-received bit.
- Symbols: I=11111, J=11000, K=10001, T=01101, R=00111. Data groups use the standard 4B5B table: 0=11110, 1=01001 … F=11101.
- All outputs registered: each strobe is asserted the clk125 cycle after the rx_bit_en cycle that completed the triggering group.
- S_HUNT: every bit is checked. sr=={J,K}=1100010001 -> S_DATA, group bit counter=0, nibble phase=low, rx_len=0, rx_active=1. Any other pattern stays in hunt.
- S_DATA: group is complete after 5 rx_bit_en counted from alignment.
  - Data group, low phase: store the nibble.
  - Data group, high phase: rx_data={nibble, stored}, rx_valid=1, rx_sof=1 if first byte, rx_len+1.
  - T: go to S_END. If the phase is high (odd nibble count), latch a pending error.
  - I: premature end. rx_eof=1, rx_err=1 -> S_HUNT.
  - Any other group (invalid, J, K, R): rx_eof=1, rx_err=1 -> S_HUNT.
  - Byte that would make rx_len exceed MAX_BYTES: not output; rx_eof=1, rx_err=1 -> S_HUNT.
- S_END: the next group is checked. R gives rx_eof=1 with rx_err=pending error. Non-R gives rx_eof=1, rx_err=1. Either way -> S_HUNT.
- A J/K arriving mid-frame is an invalid group: handled as an error end, then hunt resumes. The J/K pattern itself is not re-detected until S_HUNT.
- rx_valid and rx_eof are never asserted in the same cycle. Reset mid-frame drops the frame silently (no rx_eof).
- rx_bit_en=0 freezes all state; strobes remain single-cycle.

Test Plan:
- Clean frame: I×8, J, K, groups for bytes 0x55,0xD5,0xA7 (01011 01011, 01011 11011, 00111→no: 7=01111, A=10110), T, R, I×4, with rx_bit_en=1 always -> rx_valid ×3 with rx_data 55,D5,A7; rx_sof on first; rx_eof=1, rx_err=0; rx_len=3.
- Same frame with rx_bit_en=1 every 5th cycle only -> identical output sequence; strobes one cycle wide.
- Odd nibble: J,K, nibbles 5,5,3, T, R -> one byte 0x55, then rx_eof=1, rx_err=1.
- Invalid group 00000 after two bytes -> two valid bytes, then rx_eof=1, rx_err=1; a following J/K frame decodes cleanly.
- T followed by I instead of R -> rx_eof=1, rx_err=1. Separately, J,K then I -> rx_eof=1, rx_err=1, rx_valid never asserted.
- MAX_BYTES=4, frame of 6 bytes -> 4 rx_valid, then rx_eof=1, rx_err=1, rx_len=4. Separately, rst_n pulsed low mid-frame -> all outputs 0 immediately and no rx_eof.
